// File: rtl/dice_roll_ctrl.sv
// rtl/dice_roll_ctrl.sv - roll button to dice-counter enable sequencer with result handshake
module dice_roll_ctrl #(
    parameter int SPIN_DIV    = 2,
    parameter int SLOW_STEP   = 4,
    parameter int SLOW_PULSES = 5,
    parameter int TMR_W       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       roll_btn,
    input  logic [2:0] dice_num,
    input  logic       result_ack,
    output logic       dice_en,
    output logic [2:0] result,
    output logic       result_valid,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPIN   = 3'd1;
    localparam logic [2:0] ST_SLOW   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CNT_W = $clog2(SLOW_PULSES + 1);

    localparam logic [TMR_W-1:0] SPIN_LAST  = TMR_W'(SPIN_DIV - 1);
    localparam logic [TMR_W-1:0] SLOW_INIT  = TMR_W'(SPIN_DIV + SLOW_STEP);
    localparam logic [TMR_W-1:0] STEP       = TMR_W'(SLOW_STEP);
    localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(SLOW_PULSES - 1);

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] interval;
    logic [CNT_W-1:0] pulse_cnt;
    logic             btn_q;
    logic             armed;
    logic             rise;
    logic             face_ok;

    // armed blocks a button already held across reset release from looking like a press
    assign rise    = roll_btn & ~btn_q & armed;
    assign face_ok = (dice_num != 3'd0) && (dice_num != 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            interval     <= '0;
            pulse_cnt    <= '0;
            btn_q        <= 1'b0;
            armed        <= 1'b0;
            dice_en      <= 1'b0;
            result       <= 3'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            btn_q   <= roll_btn;
            armed   <= 1'b1;
            dice_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_SPIN;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SPIN: begin
                    if (timer == SPIN_LAST) begin
                        dice_en <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    // a release coinciding with a spin pulse still lets that pulse out
                    if (!roll_btn) begin
                        state     <= ST_SLOW;
                        interval  <= SLOW_INIT;
                        timer     <= '0;
                        pulse_cnt <= '0;
                    end
                end
                ST_SLOW: begin
                    if (timer == interval - 1'b1) begin
                        dice_en   <= 1'b1;
                        timer     <= '0;
                        interval  <= interval + STEP;
                        pulse_cnt <= pulse_cnt + 1'b1;
                        if (pulse_cnt == LAST_PULSE) begin
                            state <= ST_SETTLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // skip the cycle where our own pulse is still being applied to the counter
                    if (!dice_en) begin
                        if (face_ok) begin
                            result       <= dice_num;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= ST_DONE;
                        end else begin
                            dice_en <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb/tb_dice_roll_ctrl.sv - directed self-checking bench for dice_roll_ctrl
module tb_dice_roll_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       roll_btn;
    logic       result_ack;
    logic       dice_en;
    logic       result_valid;
    logic       busy;
    logic [2:0] dice_num;
    logic [2:0] result;
    logic [2:0] cnt;
    logic [2:0] force_val;
    logic       force_en;
    logic [2:0] exp_face;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    dice_roll_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .roll_btn(roll_btn),
        .dice_num(dice_num),
        .result_ack(result_ack),
        .dice_en(dice_en),
        .result(result),
        .result_valid(result_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] next_face(input logic [2:0] f);
        case (f)
            3'd0: next_face = 3'd1;
            3'd1: next_face = 3'd6;
            3'd6: next_face = 3'd3;
            3'd3: next_face = 3'd5;
            3'd5: next_face = 3'd4;
            3'd4: next_face = 3'd2;
            3'd2: next_face = 3'd1;
            default: next_face = 3'd1;
        endcase
    endfunction

    // dice counter stand-in, shares reset with the controller
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= 3'd0;
        else if (dice_en) cnt <= next_face(cnt);
    end
    assign dice_num = force_en ? force_val : cnt;

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) exp_face = next_face(exp_face);
    endtask

    task automatic do_ack;
        @(negedge clk); result_ack = 1'b1;
        @(negedge clk); result_ack = 1'b0;
    endtask

    task automatic run_roll(input int hold, input int swap_at, output int n, output bit ok);
        n = 0;
        roll_btn = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (dice_en) begin
                n++;
                if (n == hold) roll_btn = 1'b0;
                if (n == swap_at) force_val = 3'd3;
            end
            if (result_valid) break;
        end
        ok = result_valid;
        roll_btn = 1'b0;
    endtask

    task automatic test_reset;
        int pulses;
        int busy_hits;
        reset_n = 1'b0; roll_btn = 1'b1; result_ack = 1'b0;
        force_en = 1'b0; force_val = 3'd0; exp_face = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (dice_en !== 1'b0) begin errors++; $display("FAIL reset_dice_en got=%b want=0", dice_en); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (result !== 3'd0) begin errors++; $display("FAIL reset_result got=%0d want=0", result); end
        reset_n = 1'b1;
        pulses = 0; busy_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dice_en) pulses++;
            if (busy) busy_hits++;
        end
        checks++; if (pulses != 0 || busy_hits != 0) begin
            errors++; $display("FAIL held_btn_no_roll pulses=%0d busy_cycles=%0d want=0/0", pulses, busy_hits);
        end
        roll_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_roll;
        int n;
        bit ok;
        bit seen;
        n = 0; seen = 0; ok = 0;
        roll_btn = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dice_en) seen = 1;
        end
        if (seen) n = 1;
        // release lands on the edge that issues the second spin pulse
        @(negedge clk);
        if (dice_en) n++;
        roll_btn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dice_en) n++;
            if (result_valid) begin ok = 1; break; end
        end
        advance(n);
        checks++; if (!ok) begin errors++; $display("FAIL default_valid_timeout got=%b want=1", result_valid); end
        checks++; if (n != 7) begin errors++; $display("FAIL default_pulse_count got=%0d want=7", n); end
        checks++; if (result !== 3'd1) begin errors++; $display("FAIL default_result got=%0d want=1", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL default_busy got=%b want=0", busy); end
    endtask

    task automatic test_handshake;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            roll_btn = (i == 5 || i == 10 || i == 11) ? 1'b1 : 1'b0;
            checks++;
            if (result_valid !== 1'b1 || result !== exp_face || dice_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_done cyc=%0d valid=%b result=%0d en=%b busy=%b want 1/%0d/0/0",
                         i, result_valid, result, dice_en, busy, exp_face);
            end
        end
        roll_btn = 1'b0;
        @(negedge clk); result_ack = 1'b1;
        @(negedge clk); result_ack = 1'b0;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_clears_valid got=%b want=0", result_valid); end
        checks++; if (result !== exp_face) begin errors++; $display("FAIL ack_result_kept got=%0d want=%0d", result, exp_face); end
    endtask

    task automatic test_timing;
        int t[16];
        int n;
        int rel;
        bit ok;
        n = 0; rel = 0; ok = 0;
        @(negedge clk); roll_btn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dice_en && n < 16) begin
                t[n] = cyc;
                n++;
                if (n == 3) begin roll_btn = 1'b0; rel = cyc + 1; end
            end
            if (result_valid) begin ok = 1; break; end
        end
        advance(n);
        checks++; if (!ok || n != 8) begin errors++; $display("FAIL timing_pulses got=%0d ok=%b want=8", n, ok); end
        if (n == 8) begin
            checks++; if (t[2] - t[1] != 2) begin errors++; $display("FAIL spin_gap got=%0d want=2", t[2] - t[1]); end
            checks++; if (t[3] - rel != 6) begin errors++; $display("FAIL slow_gap1 got=%0d want=6", t[3] - rel); end
            checks++; if (t[4] - t[3] != 10) begin errors++; $display("FAIL slow_gap2 got=%0d want=10", t[4] - t[3]); end
            checks++; if (t[5] - t[4] != 14) begin errors++; $display("FAIL slow_gap3 got=%0d want=14", t[5] - t[4]); end
            checks++; if (t[6] - t[5] != 18) begin errors++; $display("FAIL slow_gap4 got=%0d want=18", t[6] - t[5]); end
            checks++; if (t[7] - t[6] != 22) begin errors++; $display("FAIL slow_gap5 got=%0d want=22", t[7] - t[6]); end
            checks++; if (t[7] - rel != 70) begin errors++; $display("FAIL decel_span got=%0d want=70", t[7] - rel); end
            checks++; if (cyc - t[7] != 2) begin errors++; $display("FAIL settle_latency got=%0d want=2", cyc - t[7]); end
        end
        checks++; if (result !== exp_face) begin errors++; $display("FAIL timing_result got=%0d want=%0d", result, exp_face); end
    endtask

    task automatic test_ack_rise;
        int hits;
        int n;
        bit ok;
        @(negedge clk); result_ack = 1'b1; roll_btn = 1'b1;
        @(negedge clk); result_ack = 1'b0;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ack_rise_idle valid=%b busy=%b want 0/0", result_valid, busy);
        end
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dice_en || busy) hits++;
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL ack_rise_consumed active_cycles=%0d want=0", hits); end
        roll_btn = 1'b0;
        @(negedge clk); roll_btn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_rise_busy got=%b want=1", busy); end
        run_roll(3, 0, n, ok);
        advance(n);
        checks++; if (!ok || n != 8) begin errors++; $display("FAIL clean_roll_pulses got=%0d ok=%b want=8", n, ok); end
        checks++; if (result !== exp_face) begin errors++; $display("FAIL clean_roll_result got=%0d want=%0d", result, exp_face); end
        do_ack;
    endtask

    task automatic test_illegal;
        int n;
        bit ok;
        force_en = 1'b1; force_val = 3'd7;
        @(negedge clk);
        run_roll(2, 8, n, ok);
        advance(n);
        checks++; if (!ok || n != 8) begin errors++; $display("FAIL illegal_extra_pulse got=%0d ok=%b want=8", n, ok); end
        checks++; if (result !== 3'd3 || result_valid !== 1'b1) begin
            errors++; $display("FAIL illegal_result got=%0d valid=%b want=3/1", result, result_valid);
        end
        do_ack;
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid_slow;
        int n;
        int hits;
        n = 0;
        @(negedge clk); roll_btn = 1'b1;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(negedge clk);
            if (dice_en) begin
                n++;
                if (n == 2) roll_btn = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_slow_busy got=%b want=1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (dice_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL async_abort en=%b busy=%b valid=%b want 0/0/0", dice_en, busy, result_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_face = 3'd0;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dice_en || busy) hits++;
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL post_reset_quiet active_cycles=%0d want=0", hits); end
        checks++; if (result !== 3'd0) begin errors++; $display("FAIL post_reset_result got=%0d want=0", result); end
    endtask

    initial begin
        test_reset;
        test_default_roll;
        test_handshake;
        test_timing;
        test_ack_rise;
        test_illegal;
        test_reset_mid_slow;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
- Sequencing controller for the 3-bit dice-sequence counter. The counter steps 0→1→6→3→5→4→2→1 on each `en`.
- Turns a player "roll" button into a burst of counter enables:
  - fast spin while the button is held;
  - then a decelerating run of pulses after release.
- Captures the settled face, presents it with a valid/ack handshake, and owns the counter's `en` input.
- Sits between the debounced button logic and the dice counter / display.

Parameters:
- SPIN_DIV, 2: cycles between `dice_en` pulses during SPIN (≥1).
- SLOW_STEP, 4: interval increment, in cycles, after each deceleration pulse (≥1).
- SLOW_PULSES, 5: number of deceleration pulses after button release (≥1).
- TMR_W, 16: width of the interval timer and interval register. Must hold SPIN_DIV + SLOW_STEP×SLOW_PULSES.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- roll_btn, input, 1: debounced, synchronous roll button, level.
- dice_num, input, 3: current counter value (counter `num`).
- result_ack, input, 1: consumer acknowledge of `result`.
- dice_en, output, 1: one-cycle enable pulse to the counter.
- result, output, 3: captured face, 1..6.
- result_valid, output, 1: `result` is new and unacknowledged.
- busy, output, 1: roll in progress (SPIN, SLOW or SETTLE).

Behaviour:
- Reset (async, `reset_n` low):
  - state = IDLE; `dice_en`, `result`, `result_valid`, `busy` = 0.
  - Timer, interval and pulse count = 0; `btn_q` = 0.
  - Reset mid-roll aborts immediately with no further `dice_en`. The counter shares `reset_n`.
- All outputs are registered. `dice_en` is high for exactly one cycle per pulse.
- `btn_q` registers `roll_btn` every cycle. Rise = `roll_btn & ~btn_q`.
- IDLE:
  - On rise → SPIN; timer = 0.
  - `roll_btn` held high through reset release does not start a roll (no rise).
- SPIN:
  - Timer increments each cycle. When timer == SPIN_DIV-1: pulse `dice_en`, timer = 0.
  - When `roll_btn` == 0 → SLOW with interval = SPIN_DIV + SLOW_STEP, timer = 0, pulse count = 0.
  - A release in the same cycle as a spin pulse: the pulse still issues.
- SLOW:
  - Timer increments. When timer == interval-1: pulse `dice_en`, timer = 0, interval += SLOW_STEP, pulse count++.
  - On the SLOW_PULSES-th pulse → SETTLE.
  - `roll_btn` is ignored; re-pressing does not restart.
- SETTLE: the counter output is valid one cycle after the last pulse. Evaluate `dice_num`:
  - 1..6: `result` = `dice_num`, `result_valid` = 1 → DONE.
  - 0 or 7 (never enabled, or illegal): pulse `dice_en` once, stay in SETTLE, re-evaluate the next cycle but one.
- DONE:
  - `result_valid` stays high and `result` is stable until `result_ack` is sampled high.
  - Then `result_valid` = 0 on the next edge → IDLE.
  - Rise in DONE without ack is ignored (not queued).
  - Ack and rise in the same cycle: → IDLE; the rise is consumed and does not start a roll.
  - `result_ack` outside DONE is ignored.
- `result` holds its last value in IDLE/SPIN/SLOW and is overwritten only in SETTLE.
- `busy` = 1 in SPIN, SLOW, SETTLE; 0 in IDLE, DONE.
- Deceleration span from release to SETTLE = Σ(SPIN_DIV + k·SLOW_STEP), k = 1..SLOW_PULSES. With defaults: 6+10+14+18+22 = 70 cycles.

Test Plan:
- Reset check: assert `reset_n` low mid-SLOW → `dice_en`/`result_valid`/`busy` = 0 immediately. No pulses after release until a new rise.
- Defaults, model counter from reset, `roll_btn` high for exactly 2 spin pulses then low:
  - expect 2 + 5 = 7 `dice_en` total;
  - sequence 1,6,3,5,4,2,1 → `result` = 1, `result_valid` = 1, `busy` = 0.
- Deceleration timing, defaults: gaps between SLOW pulses = 6, 10, 14, 18, 22 cycles; SPIN gap = 2 cycles.
- Handshake:
  - hold `result_ack` = 0 for 20 cycles in DONE → `result_valid` stays 1, `result` stable, extra rises ignored;
  - ack = 1 → `result_valid` = 0 on the next edge.
- Simultaneous ack + rise in DONE → IDLE, no SPIN, no `dice_en`. A subsequent clean rise starts a roll.
- Illegal face: force `dice_num` = 7 at SETTLE → one extra `dice_en`. When `dice_num` = 3 → `result` = 3, valid.
